data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's load/store port. Serves word reads/writes from CPU address/data.

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/ram_sp.sv | 25 ++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
// State encoding, word geometry and the byte-address to word-index helper.
package data_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } dmr_state_t;

   localparam int WORD_BYTES = 4;
   localparam int WS_CNT_W   = 4;

   // Unsigned wrap-around: an address below base becomes a huge index and decodes as unmapped.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> $clog2(WORD_BYTES);
   endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous data RAM with a registered read port.
// The read register only ever sees the address the responder holds, so it stays stable in RESP.
module ram_sp #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // NOTE: the array has no reset; clearing a RAM would turn it into a flop bank.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready load/store responder in front of the on-chip data RAM, with programmable wait states.
// Define MMIO_REG_EN to map a single register (io_reg) at IO_ADDR ahead of the RAM decode.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [DATA_W-1:0] io_reg
);

   localparam int AW = $clog2(DEPTH_WORDS);

`ifdef MMIO_REG_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   dmr_state_t           state_q, state_d;
   logic [WS_CNT_W-1:0]  cnt_q, cnt_d;
   logic                 we_q;
   logic [31:0]          addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 sel_ram_q, sel_ram_d;
   logic [DATA_W-1:0]    io_reg_q, io_reg_d;

   logic                 in_idle;
   logic                 accept;
   logic                 commit;
   logic                 cur_we;
   logic [31:0]          cur_addr;
   logic [DATA_W-1:0]    cur_wdata;
   logic [31:0]          idx;
   logic                 aligned;
   logic                 io_hit;
   logic                 ram_hit;
   logic                 ram_we;
   logic [DATA_W-1:0]    ram_rdata;

   assign in_idle = (state_q == ST_IDLE);
   assign accept  = in_idle && req_valid;

   // With zero wait states the commit edge is the accept edge, so decode straight from the request.
   assign cur_we    = in_idle ? req_we    : we_q;
   assign cur_addr  = in_idle ? req_addr  : addr_q;
   assign cur_wdata = in_idle ? req_wdata : wdata_q;

   assign idx     = word_index(cur_addr, BASE_ADDR);
   assign aligned = (cur_addr[1:0] == 2'b00);
   assign io_hit  = MMIO_EN && aligned && (cur_addr == IO_ADDR);
   assign ram_hit = !io_hit && aligned && (idx < 32'(DEPTH_WORDS));
   assign ram_we  = commit && cur_we && ram_hit;

   ram_sp #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (idx[AW-1:0]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_CNT_W'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - WS_CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      sel_ram_d   = sel_ram_q;
      io_reg_d    = io_reg_q;
      if (commit) begin
         rsp_err_d   = !(ram_hit || io_hit);
         sel_ram_d   = !cur_we && ram_hit;
         rsp_rdata_d = (!cur_we && io_hit) ? io_reg_q : '0;
         if (cur_we && io_hit) begin
            io_reg_d = cur_wdata;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         sel_ram_q   <= 1'b0;
         io_reg_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         sel_ram_q   <= sel_ram_d;
         io_reg_q    <= io_reg_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   assign req_ready = in_idle;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = (rsp_valid && sel_ram_q) ? ram_rdata : rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign io_reg    = io_reg_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with one wait state (A) and one with none (B).
module tb_data_mem_responder;

   localparam logic [31:0] IO_ADDR = 32'hFFFF_FFF0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;

   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata, a_io_reg;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata, b_io_reg;

   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.WAIT_STATES(1), .IO_ADDR(IO_ADDR)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid && !sel),
      .req_ready (a_req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (a_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (a_rsp_rdata),
      .rsp_err   (a_rsp_err),
      .io_reg    (a_io_reg)
   );

   data_mem_responder #(.WAIT_STATES(0), .IO_ADDR(IO_ADDR)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid && sel),
      .req_ready (b_req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (b_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err),
      .io_reg    (b_io_reg)
   );

   assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
   assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete access; inputs are scrambled after acceptance to prove they are ignored.
   task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 20);
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        vecs[15];
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;

      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0,          1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,          1'b1};
      vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,          1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0,          1'b1};
      vecs[6]  = '{1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 32'h0,          1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0102_0304,  1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,          1'b0};
      vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D,  1'b0};
      vecs[11] = '{1'b1, 32'h0000_0020, 32'h55AA_55AA, 32'h0,          1'b0};
      vecs[12] = '{1'b0, 32'h0000_0020, 32'h0,         32'h55AA_55AA,  1'b0};
      vecs[13] = '{1'b1, 32'h0000_0024, 32'h1357_2468, 32'h0,          1'b0};
      vecs[14] = '{1'b0, 32'h0000_0024, 32'h0,         32'h1357_2468,  1'b0};

      reset     = 1'b1;
      sel       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      #12;
      check("reset req_ready", 32'(a_req_ready), 32'd1);
      check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("reset rsp_rdata", a_rsp_rdata, 32'h0);
      check("reset rsp_err",   32'(a_rsp_err), 32'd0);
      check("reset io_reg",    a_io_reg, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Table: WAIT_STATES=1, so rsp_valid appears 2 cycles after accept.
      for (int i = 0; i < 15; i++) begin
         access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
         check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
         check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Response held for 5 cycles with rsp_ready low.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_rsp_valid && n < 20);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold%0d rsp_valid", c), 32'(a_rsp_valid), 32'd1);
         check($sformatf("hold%0d rdata", c), a_rsp_rdata, 32'hDEAD_BEEF);
         check($sformatf("hold%0d err", c), 32'(a_rsp_err), 32'd0);
         check($sformatf("hold%0d req_ready", c), 32'(a_req_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("release req_ready", 32'(a_req_ready), 32'd1);
      check("release rsp_valid", 32'(a_rsp_valid), 32'd0);

      // MMIO register at IO_ADDR.
      access(1'b1, IO_ADDR, 32'h0000_00A5, rd, er, lat);
`ifdef MMIO_REG_EN
      check("mmio store err", 32'(er), 32'd0);
      check("mmio io_reg", a_io_reg, 32'h0000_00A5);
      access(1'b0, IO_ADDR, 32'h0, rd, er, lat);
      check("mmio load rdata", rd, 32'h0000_00A5);
      check("mmio load err", 32'(er), 32'd0);
`else
      check("mmio store err", 32'(er), 32'd1);
      check("mmio io_reg", a_io_reg, 32'h0);
      access(1'b0, IO_ADDR, 32'h0, rd, er, lat);
      check("mmio load rdata", rd, 32'h0);
      check("mmio load err", 32'(er), 32'd1);
`endif

      // Reset during WAIT of a store: the store must never land.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("wait req_ready", 32'(a_req_ready), 32'd0);
      check("wait rsp_valid", 32'(a_rsp_valid), 32'd0);
      reset = 1'b1;
      #1;
      check("abort req_ready", 32'(a_req_ready), 32'd1);
      check("abort rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("abort rsp_rdata", a_rsp_rdata, 32'h0);
      check("abort rsp_err",   32'(a_rsp_err), 32'd0);
      check("abort io_reg",    a_io_reg, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      access(1'b0, 32'h20, 32'h0, rd, er, lat);
      check("abort old rdata", rd, 32'h55AA_55AA);
      check("abort old latency", 32'(lat), 32'd2);

      // WAIT_STATES=0 responder.
      sel = 1'b1;
      access(1'b1, 32'h0, 32'hA0A0_A0A0, rd, er, lat);
      check("ws0 store0 latency", 32'(lat), 32'd1);
      access(1'b1, 32'h4, 32'hB1B1_B1B1, rd, er, lat);
      check("ws0 store4 latency", 32'(lat), 32'd1);
      check("ws0 store4 err", 32'(er), 32'd0);

      // Back-to-back loads with rsp_ready held high: accepts two cycles apart.
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      check("b2b first ready", 32'(b_req_ready), 32'd1);
      @(negedge clk);
      check("b2b rsp0 valid", 32'(b_rsp_valid), 32'd1);
      check("b2b rsp0 rdata", b_rsp_rdata, 32'hA0A0_A0A0);
      check("b2b rsp0 ready", 32'(b_req_ready), 32'd0);
      req_addr = 32'h4;
      @(negedge clk);
      check("b2b idle ready", 32'(b_req_ready), 32'd1);
      check("b2b idle valid", 32'(b_rsp_valid), 32'd0);
      @(negedge clk);
      check("b2b rsp1 valid", 32'(b_rsp_valid), 32'd1);
      check("b2b rsp1 rdata", b_rsp_rdata, 32'hB1B1_B1B1);
      check("b2b rsp1 err", 32'(b_rsp_err), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b end valid", 32'(b_rsp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
